// File: rtl/sdram_fifo_ctrl_if.sv
// sdram_fifo_ctrl_if: sample stream and RAM-side signals of the FIFO controller
interface sdram_fifo_ctrl_if #(
  parameter int ADDR_WIDTH = 23,
  parameter int DATA_WIDTH = 16
);
  logic in_valid, in_ready, out_valid, out_ready, mem_we;
  logic [DATA_WIDTH-1:0] in_data, out_data, mem_din, mem_dout;
  logic [ADDR_WIDTH:0] level;
  logic [ADDR_WIDTH-1:0] mem_addr;
  modport master (
    input in_valid, in_data, out_ready, mem_dout,
    output in_ready, out_valid, out_data, level, mem_we, mem_addr, mem_din
  );
  modport slave (
    output in_valid, in_data, out_ready, mem_dout,
    input in_ready, out_valid, out_data, level, mem_we, mem_addr, mem_din
  );
endinterface

// File: rtl/sdram_fifo_ctrl.sv
// sdram_fifo_ctrl: single-port RAM used as a circular sample FIFO with a 2-entry output buffer
module sdram_fifo_ctrl #(
  parameter int ADDR_WIDTH = 23,
  parameter int DATA_WIDTH = 16
) (
  input logic clk,
  input logic reset,
  sdram_fifo_ctrl_if.master bus
);
  localparam logic [0:0] G_WR = 1'b0, G_RD = 1'b1;
  logic [ADDR_WIDTH:0] wr_ptr, rd_ptr, level;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] buf0, buf1;
  logic [1:0] buf_count;
  logic [0:0] last_grant;
  logic rd_pending, full, empty, want_wr, want_rd, grant_wr, grant_rd, push, pop;
  // status, credit-checked requests and alternating arbitration; nothing is granted while in reset
  always_comb begin
    level = wr_ptr - rd_ptr;
    full = level[ADDR_WIDTH];
    empty = level == '0;
    want_wr = !reset && bus.in_valid && !full;
    want_rd = !reset && !empty && ({1'b0, buf_count} + {2'b0, rd_pending}) < 3'd2;
    grant_wr = want_wr && (!want_rd || last_grant == G_RD);
    grant_rd = want_rd && !grant_wr;
    push = rd_pending;
    pop = buf_count != 2'd0 && bus.out_ready;
  end
  assign bus.in_ready = grant_wr;
  assign bus.mem_we = grant_wr;
  assign bus.mem_addr = grant_wr ? wr_ptr[ADDR_WIDTH-1:0] : grant_rd ? rd_ptr[ADDR_WIDTH-1:0] : addr_q;
  assign bus.mem_din = grant_wr ? bus.in_data : '0;
  assign bus.level = level;
  assign bus.out_valid = buf_count != 2'd0;
  assign bus.out_data = buf0;
  // pointers, read-in-flight flag and output buffer; a returning read lands behind whatever survives the pop
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      addr_q <= '0;
      last_grant <= G_WR;
      rd_pending <= 1'b0;
      buf_count <= '0;
      buf0 <= '0;
      buf1 <= '0;
    end else begin
      wr_ptr <= wr_ptr + (ADDR_WIDTH+1)'(grant_wr);
      rd_ptr <= rd_ptr + (ADDR_WIDTH+1)'(grant_rd);
      addr_q <= bus.mem_addr;
      if (grant_wr || grant_rd) last_grant <= grant_rd ? G_RD : G_WR;
      rd_pending <= grant_rd;
      buf_count <= buf_count + 2'(push) - 2'(pop);
      if (pop) buf0 <= buf1;
      if (push && buf_count - 2'(pop) == 2'd0) buf0 <= bus.mem_dout;
      if (push && buf_count - 2'(pop) != 2'd0) buf1 <= bus.mem_dout;
    end
  end
endmodule

// File: tb/tb_sdram_fifo_ctrl.sv
// tb_sdram_fifo_ctrl: directed scoreboard bench for the RAM-backed sample FIFO
module tb_sdram_fifo_ctrl;
  localparam int AW = 4;
  localparam int DW = 16;
  logic clk = 1'b0;
  logic reset;
  int total = 0, bad = 0, pops = 0;
  logic [DW-1:0] q[$];
  logic [DW-1:0] mem [2**AW];
  logic [AW-1:0] acc_addr, last_wa = '0;
  logic wrapped = 1'b0;
  sdram_fifo_ctrl_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();
  sdram_fifo_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (.clk(clk), .reset(reset), .bus(bus.master));
  always #5 clk = ~clk;
  // synchronous-read RAM model: data returns the cycle after the address
  always @(posedge clk) begin
    if (bus.mem_we) mem[bus.mem_addr] <= bus.mem_din;
    bus.mem_dout <= mem[bus.mem_addr];
  end
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask
  // scoreboard: pop-and-compare before push so an item never matches itself
  always @(negedge clk) begin
    if (reset) q.delete();
    else begin
      if (bus.out_valid && bus.out_ready) begin
        pops++;
        chk("sb_underflow", q.size() != 0, 1);
        if (q.size() != 0) chk("sb_data", bus.out_data, q.pop_front());
      end
      if (bus.in_valid && bus.in_ready) q.push_back(bus.in_data);
      if (bus.mem_we) begin
        if (bus.mem_addr == '0 && last_wa == AW'(15)) wrapped = 1'b1;
        last_wa = bus.mem_addr;
      end
    end
  end
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic send(input logic [DW-1:0] v);
    int n = 0;
    bus.in_valid = 1'b1;
    bus.in_data = v;
    @(negedge clk);
    while (!bus.in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("send_accept", bus.in_ready, 1);
    acc_addr = bus.mem_addr;
    tick();
    bus.in_valid = 1'b0;
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    int acc, idx, n;
    logic a;
    reset = 1'b1;
    bus.in_valid = 1'b0;
    bus.in_data = '0;
    bus.out_ready = 1'b0;
    repeat (2) tick();
    reset = 1'b0;
    @(negedge clk);
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_level", bus.level, 0);
    chk("rst_mem_we", bus.mem_we, 0);
    chk("rst_mem_addr", bus.mem_addr, 0);
    chk("rst_mem_din", bus.mem_din, 0);
    tick();
    // 1: four writes, buffer fills with the first two
    for (int k = 1; k <= 4; k++) begin
      send(DW'(k));
      chk("t1_addr", acc_addr, k - 1);
    end
    repeat (5) tick();
    @(negedge clk);
    chk("t1_level", bus.level, 2);
    chk("t1_out_valid", bus.out_valid, 1);
    chk("t1_out_data", bus.out_data, 16'h0001);
    tick();
    bus.out_ready = 1'b1;
    repeat (20) tick();
    chk("t1_drained", q.size(), 0);
    chk("t1_level_end", bus.level, 0);
    // 2: latency N+3 in an empty system
    send(16'hBEEF);
    @(negedge clk);
    chk("t2_n1", bus.out_valid, 0);
    @(negedge clk);
    chk("t2_n2", bus.out_valid, 0);
    @(negedge clk);
    chk("t2_n3", bus.out_valid, 1);
    chk("t2_n3_data", bus.out_data, 16'hBEEF);
    @(negedge clk);
    chk("t2_n4", bus.out_valid, 0);
    tick();
    // 3: fill RAM and buffer, then drain in order
    bus.out_ready = 1'b0;
    bus.in_valid = 1'b1;
    bus.in_data = '0;
    acc = 0;
    repeat (60) begin
      @(negedge clk);
      a = bus.in_ready;
      tick();
      if (a) begin
        acc++;
        bus.in_data = DW'(acc);
      end
    end
    @(negedge clk);
    chk("t3_accepted", acc, 18);
    chk("t3_level_full", bus.level, 16);
    chk("t3_ready_full", bus.in_ready, 0);
    tick();
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    repeat (60) tick();
    chk("t3_drained", q.size(), 0);
    chk("t3_level_end", bus.level, 0);
    // 4: random streaming across the pointer wrap
    pops = 0;
    wrapped = 1'b0;
    idx = 0;
    n = 0;
    while (idx < 100 && n < 3000) begin
      bus.in_valid = 1'($urandom_range(0, 1));
      bus.in_data = DW'(idx);
      bus.out_ready = 1'($urandom_range(0, 1));
      @(negedge clk);
      a = bus.in_valid && bus.in_ready;
      tick();
      if (a) idx++;
      n++;
    end
    chk("t4_sent", idx, 100);
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    repeat (80) tick();
    chk("t4_drained", q.size(), 0);
    chk("t4_pops", pops, 100);
    chk("t4_level_end", bus.level, 0);
    chk("t4_wrapped", wrapped, 1);
    // 5: continuous traffic alternates grants, one sample per two cycles
    bus.in_data = 16'h0500;
    for (int i = 0; i < 20; i++) begin
      bus.in_valid = 1'b1;
      bus.out_ready = 1'b1;
      @(negedge clk);
      a = bus.in_ready;
      chk("t5_wgrant", a, (i % 2) == 0);
      chk("t5_out_valid", bus.out_valid, i >= 3 && (i % 2) == 1);
      tick();
      if (a) bus.in_data = bus.in_data + 16'd1;
    end
    bus.in_valid = 1'b0;
    repeat (20) tick();
    chk("t5_drained", q.size(), 0);
    // 6: reset while a read is in flight
    bus.out_ready = 1'b0;
    for (int k = 0; k < 7; k++) send(DW'(16'h0060 + k));
    repeat (4) tick();
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    n = 0;
    @(negedge clk);
    while (!dut.grant_rd && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("t6_read_seen", dut.grant_rd, 1);
    chk("t6_level_pre", bus.level, 5);
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    @(negedge clk);
    chk("t6_level", bus.level, 0);
    chk("t6_out_valid", bus.out_valid, 0);
    chk("t6_mem_we", bus.mem_we, 0);
    tick();
    send(16'h1234);
    chk("t6_addr", acc_addr, 0);
    bus.out_ready = 1'b1;
    pops = 0;
    repeat (10) tick();
    chk("t6_pops", pops, 1);
    chk("t6_drained", q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
